// File: rtl/rv_isa_pkg.sv
// RV32 base-ISA opcodes, format enum, decoded-entry struct and decoder.
// decode() splits a raw word into fields plus a 64-bit sign-extended imm.
package rv_isa_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // Widest supported XLEN / PC; narrower users take the low bits.
    localparam int IMM_MAX = 64;
    localparam int PC_MAX  = 64;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [2:0]         funct3;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [6:0]         funct7;
        fmt_e               fmt;
        logic [IMM_MAX-1:0] imm;
        logic               illegal;
        logic [PC_MAX-1:0]  pc;
    } dec_t;

    function automatic dec_t decode(
        input logic [31:0]       ins,
        input logic [PC_MAX-1:0] pc
    );
        dec_t d;
        logic [IMM_MAX-1:0] s;
        s         = {IMM_MAX{ins[31]}};
        d.opcode  = ins[6:0];
        d.rd      = ins[11:7];
        d.funct3  = ins[14:12];
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        d.funct7  = ins[31:25];
        d.pc      = pc;
        d.fmt     = FMT_R;
        d.imm     = '0;
        d.illegal = 1'b0;
        // Every listed opcode ends in 2'b11, so a bad ins[1:0]
        // falls into the default arm with unknown opcodes.
        unique case (ins[6:0])
            OPC_OP: d.fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM: begin
                d.fmt = FMT_I;
                d.imm = {s[IMM_MAX-1:12], ins[31:20]};
            end
            OPC_STORE: begin
                d.fmt = FMT_S;
                d.imm = {s[IMM_MAX-1:12], ins[31:25], ins[11:7]};
            end
            OPC_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {s[IMM_MAX-1:13], ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {s[IMM_MAX-1:32], ins[31:12], 12'h000};
            end
            OPC_JAL: begin
                d.fmt = FMT_J;
                d.imm = {s[IMM_MAX-1:21], ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Ports: in_valid/in_ready/in_data upstream, out_* downstream, flush.
module rv_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e state;
    T       skid;
    logic   in_fire;
    logic   out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // out_data is the main entry; in_ready is registered so
    // out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid      <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid     <= in_data;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (in_fire) begin
                        out_data <= in_data;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/instr_field_decoder.sv
// Registered RV32 field splitter / immediate generator with skid buffer.
// Ports: in_* handshake + word/pc, out_* handshake + decoded fields, flush.
module instr_field_decoder
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    dec_t in_dec;
    dec_t out_dec;
    logic unused_hi;

    assign in_dec = decode(in_ins, PC_MAX'(in_pc));

    rv_skid_buf #(.T(dec_t)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_dec)
    );

    assign out_pc      = out_dec.pc[PC_W-1:0];
    assign out_opcode  = out_dec.opcode;
    assign out_rd      = out_dec.rd;
    assign out_funct3  = out_dec.funct3;
    assign out_rs1     = out_dec.rs1;
    assign out_rs2     = out_dec.rs2;
    assign out_funct7  = out_dec.funct7;
    assign out_fmt     = out_dec.fmt;
    assign out_imm     = out_dec.imm[XLEN-1:0];
    assign out_illegal = out_dec.illegal;

    // Stored imm/pc are max width; bits above XLEN/PC_W are dropped.
    assign unused_hi = ^{out_dec.imm, out_dec.pc};

endmodule

// File: tb/tb_instr_field_decoder.sv
// Randomised + directed bench for instr_field_decoder (XLEN 32 and 64).
// A FIFO-of-words model predicts valid/ready and all decoded fields.
module tb_instr_field_decoder;
    import rv_isa_pkg::*;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        out_ready = 0;
    logic [31:0] in_ins = 0;
    logic [31:0] in_pc = 0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_fmt;

    logic        in_ready_w, out_valid_w, out_illegal_w;
    logic [31:0] out_pc_w;
    logic [63:0] out_imm_w;
    logic [6:0]  out_opcode_w, out_funct7_w;
    logic [4:0]  out_rd_w, out_rs1_w, out_rs2_w;
    logic [2:0]  out_funct3_w, out_fmt_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_field_decoder #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct7(out_funct7), .out_fmt(out_fmt),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    instr_field_decoder #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_pc(out_pc_w), .out_opcode(out_opcode_w),
        .out_rd(out_rd_w), .out_funct3(out_funct3_w),
        .out_rs1(out_rs1_w), .out_rs2(out_rs2_w),
        .out_funct7(out_funct7_w), .out_fmt(out_fmt_w),
        .out_imm(out_imm_w), .out_illegal(out_illegal_w)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_ill(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic fmt_e ref_fmt(input logic [31:0] w);
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return FMT_I;
            7'h23: return FMT_S;
            7'h63: return FMT_B;
            7'h37, 7'h17: return FMT_U;
            7'h6F: return FMT_J;
            default: return FMT_R;
        endcase
    endfunction

    function automatic longint ref_imm(input logic [31:0] w);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [31:0] u32;
        logic signed [20:0] j21;
        if (ref_ill(w)) return 0;
        case (ref_fmt(w))
            FMT_I: begin
                i12 = w[31:20];
                return longint'(i12);
            end
            FMT_S: begin
                i12 = {w[31:25], w[11:7]};
                return longint'(i12);
            end
            FMT_B: begin
                b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                return longint'(b13);
            end
            FMT_U: begin
                u32 = {w[31:12], 12'h000};
                return longint'(u32);
            end
            FMT_J: begin
                j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                return longint'(j21);
            end
            default: return 0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    // Capacity-2 FIFO: pop then push, push only if not full before edge.
    always @(posedge clk or negedge rst_n) begin
        bit push;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            push = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (push) q.push_back('{in_ins, in_pc});
        end
    end

    logic [31:0] w;
    longint      ei;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", {out_valid, out_valid_w}, 0);
            chk("rst_ready", {in_ready, in_ready_w}, 2'b11);
            chk("rst_pc_imm", {out_pc, out_imm}, 0);
            chk("rst_fields", {out_opcode, out_rd, out_funct3,
                out_rs1, out_rs2, out_funct7, out_fmt,
                out_illegal}, 0);
            chk("rst_imm64", out_imm_w, 0);
        end else begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready64", in_ready_w, q.size() < 2);
            chk("out_valid64", out_valid_w, q.size() > 0);
            if (q.size() > 0) begin
                w  = q[0].ins;
                ei = ref_imm(w);
                chk("pc", out_pc, q[0].pc);
                chk("opcode", out_opcode, w[6:0]);
                chk("rd", out_rd, w[11:7]);
                chk("funct3", out_funct3, w[14:12]);
                chk("rs1", out_rs1, w[19:15]);
                chk("rs2", out_rs2, w[24:20]);
                chk("funct7", out_funct7, w[31:25]);
                chk("fmt", out_fmt, ref_fmt(w));
                chk("imm", out_imm, ei[31:0]);
                chk("illegal", out_illegal, ref_ill(w));
                chk("pc64", out_pc_w, q[0].pc);
                chk("imm64", out_imm_w, ei);
                chk("fmt64", out_fmt_w, ref_fmt(w));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
        7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7) < 6) r[6:0] = opcs[$urandom_range(10)];
        return r;
    endfunction

    task automatic send_one(input logic [31:0] x);
        @(negedge clk);
        in_valid  = 1;
        in_ins    = x;
        in_pc     = $urandom;
        out_ready = 1;
        @(negedge clk);
        in_valid  = 0;
    endtask

    task automatic fill_two();
        @(negedge clk);
        out_ready = 0;
        in_valid  = 1;
        in_ins    = rand_instr();
        in_pc     = $urandom;
        @(negedge clk);
        in_ins    = rand_instr();
        in_pc     = $urandom;
        @(negedge clk);
        in_valid  = 0;
    endtask

    int  n;
    bit  rdy;

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1;

        chk("model_lui", ref_imm(32'h123450B7), 64'h12345000);
        chk("model_addi", ref_imm(32'hFFF00093), '1);
        chk("model_beq", ref_imm(32'hFE000EE3),
            64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_jal", ref_imm(32'h001000EF), 64'h800);
        chk("model_lui64", ref_imm(32'h800000B7),
            64'hFFFF_FFFF_8000_0000);
        chk("model_ill", {ref_ill(32'h7F), ref_ill(32'h10)}, 2'b11);

        send_one(32'h123450B7);
        chk("t1_rd", out_rd, 1);
        chk("t1_fmt", out_fmt, FMT_U);
        chk("t1_imm", out_imm, 32'h12345000);
        chk("t1_ill", out_illegal, 0);
        send_one(32'hFFF00093);
        chk("t2_addi", {out_fmt, out_imm}, {FMT_I, 32'hFFFFFFFF});
        send_one(32'hFE000EE3);
        chk("t2_beq", {out_fmt, out_imm}, {FMT_B, 32'hFFFFFFFC});
        send_one(32'h001000EF);
        chk("t2_jal", {out_fmt, out_imm}, {FMT_J, 32'h00000800});
        send_one(32'h0000007F);
        chk("t5_bad_opc", {out_illegal, out_fmt, out_imm},
            {1'b1, FMT_R, 32'h0});
        send_one(32'h00000010);
        chk("t5_bad_lsb", {out_illegal, out_fmt, out_imm},
            {1'b1, FMT_R, 32'h0});
        send_one(32'h800000B7);
        chk("t6_lui64", out_imm_w, 64'hFFFF_FFFF_8000_0000);

        // backpressure: 4 words, out_ready low for 3 cycles
        @(negedge clk);
        out_ready = 0;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (c == 2) chk("t3_full", in_ready, 0);
            if (c == 3) out_ready = 1;
            in_valid = 1;
            in_ins   = rand_instr();
            in_pc    = c;
            rdy      = in_ready;
            @(negedge clk);
            if (rdy) n++;
        end
        in_valid = 0;
        chk("t3_sent", n, 4);
        repeat (4) @(negedge clk);
        chk("t3_drained", out_valid, 0);

        // flush with TWO full and a word offered
        fill_two();
        chk("t4_two", in_ready, 0);
        flush    = 1;
        in_valid = 1;
        in_ins   = 32'h00500093;
        @(negedge clk);
        flush    = 0;
        in_valid = 0;
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        out_ready = 1;
        repeat (3) @(negedge clk);
        chk("t4_gone", out_valid, 0);

        // async reset with TWO full
        fill_two();
        #2 rst_n = 0;
        #1;
        chk("t6_rst_valid", {out_valid, out_valid_w}, 0);
        chk("t6_rst_ready", {in_ready, in_ready_w}, 2'b11);
        @(negedge clk);
        #2 rst_n = 1;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = $urandom_range(3) != 0;
            in_ins    = rand_instr();
            in_pc     = $urandom;
            out_ready = $urandom_range(2) != 0;
            flush     = $urandom_range(24) == 0;
        end
        @(negedge clk);
        in_valid = 0;
        flush    = 0;
        out_ready = 1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
